// File: rtl/axi4_write_master.sv
// Single-outstanding AXI4 INCR write-burst master.
// An upstream command (start address and AWLEN-encoded length) is checked,
// issued on AW, then its data beats are streamed straight from the upstream
// port onto W. A done pulse reports the B response to the upstream side.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// ADDR   | AWVALID high until the AW handshake
// DATA   | upstream beats passed through to W, beats counted
// RESP   | BREADY high until BVALID
// DONE   | one-cycle done pulse carrying the burst status
module axi4_write_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  output logic                  WLAST,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            resp_q, resp_d;

  logic                  misaligned;
  logic                  crosses_4k;
  logic [15:0]           span_end;
  logic                  beat_hs;

  // Byte offset one past the last beat within the 4KB page; 16 bits holds
  // the worst case (4095 + 256 beats * 8 bytes) without wrapping.
  assign span_end   = {4'd0, cmd_addr[11:0]} + (({8'd0, cmd_len} + 16'd1) << SZ);
  assign crosses_4k = (span_end > 16'd4096);
  assign misaligned = |cmd_addr[SZ-1:0];

  assign AWSIZE  = 3'(SZ);
  assign AWADDR  = addr_q;
  assign AWLEN   = len_q;
  assign WDATA   = wr_data;
  assign beat_hs = WVALID & WREADY;

  // State and burst registers; reset aborts any burst silently.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    resp_d    = resp_q;
    cmd_ready = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    WLAST     = 1'b0;
    wr_ready  = 1'b0;
    BREADY    = 1'b0;
    done      = 1'b0;
    done_resp = 2'b00;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          cnt_d  = '0;
          if (misaligned || crosses_4k) begin
            resp_d  = 2'b10;
            state_d = S_DONE;
          end else begin
            state_d = S_ADDR;
          end
        end
      end

      S_ADDR: begin
        AWVALID = 1'b1;
        if (AWREADY) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        WVALID   = wr_valid;
        wr_ready = WREADY;
        WLAST    = (cnt_q == len_q);
        if (beat_hs) begin
          // The last beat leaves DATA instead of incrementing, so a
          // 256-beat burst never wraps the counter.
          if (cnt_q == len_q) begin
            cnt_d   = '0;
            state_d = S_RESP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      S_RESP: begin
        BREADY = 1'b1;
        if (BVALID) begin
          resp_d  = BRESP;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done      = 1'b1;
        done_resp = resp_q;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
